// File: rtl/wca_port_scheduler_pkg.sv
// Shared PIF command/status codes and scheduler state encodings.
// Extends the single-channel WcaPortDefs set for the multi-port scheduler.
package wca_port_scheduler_pkg;

  localparam logic [1:0] PIFCMD_IDLE   = 2'b00;
  localparam logic [1:0] PIFCMD_READ   = 2'b01;
  localparam logic [1:0] PIFCMD_WRITE  = 2'b10;
  localparam logic [1:0] PIFCMD_STATUS = 2'b11;

  localparam logic [2:0] PIFSTAT_IDLE  = 3'd0;
  localparam logic [2:0] PIFSTAT_READ  = 3'd1;
  localparam logic [2:0] PIFSTAT_WRITE = 3'd2;
  localparam logic [2:0] PIFSTAT_DONE  = 3'd3;
  localparam logic [2:0] PIFSTAT_ERROR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_SELECT        = 3'd1,
    S_ADDR_WAIT     = 3'd2,
    S_CMD           = 3'd3,
    S_CMD_WAIT      = 3'd4,
    S_WAIT_COMPLETE = 3'd5
  } sched_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wca_rr_arbiter.sv
// Combinational round-robin picker: first eligible index after `last`,
// wrapping modulo N, with `last` itself as the final candidate.
module wca_rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         valid
);

  logic [W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last) + i) % N);
      if (!valid && eligible[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/wca_port_scheduler.sv
// Round-robin scheduler multiplexing COUNT_PORTS logical ports onto one PIF,
// with address/command settle delays and a WAIT_COMPLETE watchdog.
module wca_port_scheduler
  import wca_port_scheduler_pkg::*;
#(
  parameter int COUNT_PORTS = 4,
  parameter int NBITS_ADDR  = 2,
  parameter int ADDR_SETTLE = 3,
  parameter int CMD_SETTLE  = 2,
  parameter int TIMEOUT     = 1024,
  parameter int FIXED_ADDR  = -1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [COUNT_PORTS-1:0]   portReq,
  input  logic [2*COUNT_PORTS-1:0] portCmd,
  output logic [NBITS_ADDR+1:0]    pifCtrl,
  input  logic                     pifBusy,
  input  logic [2:0]               pifState,
  output logic [NBITS_ADDR-1:0]    portAddr,
  output logic [COUNT_PORTS-1:0]   portRead,
  output logic [COUNT_PORTS-1:0]   portWrite,
  output logic                     timeoutErr,
  output logic [NBITS_ADDR-1:0]    errPort
);

  localparam int CW = $clog2(max2(TIMEOUT, 16)) + 1;
  localparam bit FIXED = (FIXED_ADDR >= 0);
  localparam logic [NBITS_ADDR-1:0] RST_ADDR =
    FIXED ? NBITS_ADDR'(FIXED_ADDR) : NBITS_ADDR'(COUNT_PORTS - 1);

  sched_state_e          state;
  logic [1:0]            cmd;
  logic [CW-1:0]         cnt;
  logic                  seeded;
  logic [COUNT_PORTS-1:0] elig;
  logic [1:0]            cmds [COUNT_PORTS];
  logic [NBITS_ADDR-1:0] gnt;
  logic                  gntValid;
  logic [1:0]            selCmd;

  for (genvar i = 0; i < COUNT_PORTS; i++) begin : g_port
    assign cmds[i]      = portCmd[2*i +: 2];
    assign elig[i]      = portReq[i] && (portCmd[2*i +: 2] != PIFCMD_IDLE) &&
                          (!FIXED || i == FIXED_ADDR);
    assign portRead[i]  = !reset && (portAddr == NBITS_ADDR'(i)) && (pifState == PIFSTAT_READ);
    assign portWrite[i] = !reset && (portAddr == NBITS_ADDR'(i)) && (pifState == PIFSTAT_WRITE);
  end

  wca_rr_arbiter #(.N(COUNT_PORTS), .W(NBITS_ADDR)) u_arb (
    .eligible (elig),
    .last     (portAddr),
    .grant    (gnt),
    .valid    (gntValid)
  );

  // A dropped request reads as IDLE so CMD can abandon the slot.
  assign selCmd  = portReq[portAddr] ? cmds[portAddr] : PIFCMD_IDLE;
  assign pifCtrl = {portAddr, cmd};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd        <= PIFCMD_IDLE;
      portAddr   <= RST_ADDR;
      cnt        <= '0;
      seeded     <= 1'b0;
      timeoutErr <= 1'b0;
      errPort    <= '0;
    end else begin
      timeoutErr <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd <= PIFCMD_IDLE;
          if (enable && |elig) state <= S_SELECT;
        end
        S_SELECT: begin
          if (gntValid) begin
            portAddr <= gnt;
            seeded   <= 1'b1;
            cnt      <= '0;
            // A fixed port still settles once after reset.
            if (ADDR_SETTLE == 0 || (gnt == portAddr && (!FIXED || seeded)))
              state <= S_CMD;
            else
              state <= S_ADDR_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADDR_WAIT: begin
          if (cnt == CW'(ADDR_SETTLE - 1)) state <= S_CMD;
          else cnt <= cnt + 1'b1;
        end
        S_CMD: begin
          cmd   <= selCmd;
          cnt   <= '0;
          state <= (selCmd == PIFCMD_IDLE) ? S_IDLE : S_CMD_WAIT;
        end
        S_CMD_WAIT: begin
          if (cnt == CW'(CMD_SETTLE - 1)) begin
            state <= S_WAIT_COMPLETE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_COMPLETE: begin
          // cmd stays up through the entry cycle; the PIF has not yet had a
          // cycle to raise busy, so completion is only honoured from cycle 2.
          cmd <= PIFCMD_IDLE;
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (cnt != '0 && !pifBusy) begin
            state <= S_IDLE;
          end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1) && pifBusy) begin
            timeoutErr <= 1'b1;
            errPort    <= portAddr;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wca_port_scheduler.sv
// Directed bench for wca_port_scheduler: reset, round-robin order, settle
// timing, watchdog, withdrawn request and read/write decode.
module tb_wca_port_scheduler;
  import wca_port_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, pifBusy;
  logic [3:0] portReq;
  logic [7:0] portCmd;
  logic [3:0] pifCtrl;
  logic [2:0] pifState;
  logic [1:0] portAddr, errPort;
  logic [3:0] portRead, portWrite;
  logic       timeoutErr;

  wca_port_scheduler #(
    .COUNT_PORTS(4), .NBITS_ADDR(2), .ADDR_SETTLE(3), .CMD_SETTLE(2),
    .TIMEOUT(16), .FIXED_ADDR(-1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .portReq(portReq),
    .portCmd(portCmd), .pifCtrl(pifCtrl), .pifBusy(pifBusy),
    .pifState(pifState), .portAddr(portAddr), .portRead(portRead),
    .portWrite(portWrite), .timeoutErr(timeoutErr), .errPort(errPort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cmd pulse and timeout pulse log, sampled on the falling edge
  int         n_pulse = 0, cur_w = 0;
  int         rise_cyc [32];
  logic [1:0] rise_addr [32];
  logic [1:0] rise_cmd [32];
  int         width [32];
  logic [1:0] prev_cmd = 2'b00;
  int         to_n = 0, to_cyc = 0, to_w = 0;
  logic       prev_to = 1'b0;

  always @(negedge clk) begin
    if (pifCtrl[1:0] != 2'b00) begin
      if (prev_cmd == 2'b00) begin
        if (n_pulse < 32) begin
          rise_cyc[n_pulse]  = cyc;
          rise_addr[n_pulse] = pifCtrl[3:2];
          rise_cmd[n_pulse]  = pifCtrl[1:0];
        end
        n_pulse++;
        cur_w = 1;
      end else cur_w++;
    end else if (prev_cmd != 2'b00 && n_pulse >= 1 && n_pulse <= 32) begin
      width[n_pulse-1] = cur_w;
    end
    prev_cmd = pifCtrl[1:0];
    if (timeoutErr) begin
      if (!prev_to) begin to_n++; to_cyc = cyc; to_w = 1; end
      else to_w++;
    end
    prev_to = timeoutErr;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int b = 0;
    while (n_pulse < target && b < budget) begin @(negedge clk); b++; end
    chk(tag, n_pulse, target);
  endtask

  int base, c0, tb0;
  logic [1:0] exp_rr [4];

  initial begin
    reset = 1'b1; enable = 1'b1; portReq = '0; portCmd = '0;
    pifBusy = 1'b0; pifState = PIFSTAT_READ;
    repeat (3) @(negedge clk);
    chk("rst_cmd", pifCtrl[1:0], 2'b00);
    chk("rst_addr", portAddr, 2'd3);
    chk("rst_to", timeoutErr, 1'b0);
    chk("rst_errport", errPort, 2'd0);
    chk("rst_rd", portRead, 4'b0000);
    reset = 1'b0; pifState = PIFSTAT_IDLE;
    @(negedge clk);

    // only port 1: one address settle, then same-port repeats
    base = n_pulse; c0 = cyc;
    portReq = 4'b0010; portCmd = 8'b00_00_01_00;
    wait_pulses(base + 3, 60, "same_cnt");
    portReq = '0;
    repeat (12) @(negedge clk);
    chk("same_lat", rise_cyc[base] - c0, 6);
    for (int k = 0; k < 3; k++) chk("same_addr", rise_addr[base+k], 2'd1);
    chk("same_per1", rise_cyc[base+1] - rise_cyc[base], 7);
    chk("same_per2", rise_cyc[base+2] - rise_cyc[base+1], 7);
    chk("same_width", width[base], 3);

    // ports 0 and 2 from reset address 3
    reset = 1'b1; repeat (2) @(negedge clk);
    reset = 1'b0; @(negedge clk);
    base = n_pulse;
    portReq = 4'b0101; portCmd = 8'b00_01_00_01;
    wait_pulses(base + 4, 80, "rr_cnt");
    portReq = '0;
    repeat (15) @(negedge clk);
    exp_rr[0] = 2'd0; exp_rr[1] = 2'd2; exp_rr[2] = 2'd0; exp_rr[3] = 2'd2;
    for (int k = 0; k < 4; k++) chk("rr_addr", rise_addr[base+k], exp_rr[k]);
    for (int k = 1; k < 4; k++) chk("rr_per", rise_cyc[base+k] - rise_cyc[base+k-1], 10);
    chk("rr_cmd", rise_cmd[base], PIFCMD_READ);

    // decode at portAddr 2
    pifState = PIFSTAT_WRITE; #1;
    chk("dec_wr", portWrite, 4'b0100);
    chk("dec_wr_rd", portRead, 4'b0000);
    pifState = PIFSTAT_READ; #1;
    chk("dec_rd", portRead, 4'b0100);
    chk("dec_rd_wr", portWrite, 4'b0000);
    pifState = PIFSTAT_IDLE;
    @(negedge clk);

    // watchdog on port 2, then port 3 becomes eligible
    pifBusy = 1'b1; base = n_pulse; tb0 = to_n;
    portReq = 4'b0100; portCmd = 8'b00_01_00_00;
    wait_pulses(base + 1, 30, "wd_first");
    portReq = 4'b1100; portCmd = 8'b10_01_00_00;
    for (int b = 0; b < 40 && to_n == tb0; b++) @(negedge clk);
    pifBusy = 1'b0;
    chk("wd_seen", to_n, tb0 + 1);
    wait_pulses(base + 2, 30, "wd_next_cnt");
    portReq = '0;
    repeat (15) @(negedge clk);
    chk("wd_addr", rise_addr[base], 2'd2);
    chk("wd_cyc", to_cyc - rise_cyc[base], 18);
    chk("wd_width", to_w, 1);
    chk("wd_errport", errPort, 2'd2);
    chk("wd_next", rise_addr[base+1], 2'd3);
    chk("wd_next_cmd", rise_cmd[base+1], PIFCMD_WRITE);

    // enable low blocks new selections
    enable = 1'b0; base = n_pulse;
    portReq = 4'b0010; portCmd = 8'b00_00_01_00;
    repeat (15) @(negedge clk);
    chk("en_gate", n_pulse, base);
    portReq = '0; enable = 1'b1;
    @(negedge clk);

    // port 1 withdraws during ADDR_WAIT (address 3 -> 1)
    base = n_pulse;
    portReq = 4'b0010;
    repeat (3) @(negedge clk);
    portReq = '0;
    repeat (20) @(negedge clk);
    chk("wdr_nopulse", n_pulse, base);
    chk("wdr_addr", portAddr, 2'd1);
    chk("wdr_cmd", pifCtrl[1:0], 2'b00);

    // re-request on the current port: 3-clock latency
    c0 = cyc; portReq = 4'b0010;
    wait_pulses(base + 1, 20, "rep_cnt");
    portReq = '0;
    repeat (10) @(negedge clk);
    chk("rep_lat", rise_cyc[base] - c0, 3);

    // reset held 3 cycles mid WAIT_COMPLETE
    pifBusy = 1'b1; base = n_pulse; tb0 = to_n;
    portReq = 4'b0010;
    wait_pulses(base + 1, 20, "mid_cnt");
    portReq = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1; pifState = PIFSTAT_READ;
    @(negedge clk);
    chk("mid_cmd", pifCtrl[1:0], 2'b00);
    chk("mid_addr", portAddr, 2'd3);
    chk("mid_to", timeoutErr, 1'b0);
    chk("mid_errport", errPort, 2'd0);
    chk("mid_rd", portRead, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0; pifBusy = 1'b0; pifState = PIFSTAT_IDLE;
    repeat (30) @(negedge clk);
    chk("post_to", to_n, tb0);
    chk("post_pulse", n_pulse, base + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
